// File: rtl/pe_pkg.sv
// Shared types and defaults for the PE MAC sequencer slice.
// FSM state encoding, scratchpad depth defaults, counter widths.
package pe_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_LOAD_A,
    S_COMPUTE,
    S_OUT,
    S_DONE
  } seq_state_t;

  localparam int FILT_MAX_DEF = 4;
  localparam int ACT_MAX_DEF  = 16;
  localparam int TAP_CW = $clog2(FILT_MAX_DEF + 1);
  localparam int ACT_CW = $clog2(ACT_MAX_DEF + 1);

endpackage

// File: rtl/pe_spad.sv
// Register-file scratchpad: 1 write port, 1 combinational read port.
// Ports: clk, we_i/waddr_i/wdata_i (write), raddr_i/rdata_o (read).
module pe_spad #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  // Contents deliberately survive reset.
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pe_mac_sequencer.sv
// Row-stationary 1D conv sequencer driving an external 1-cycle MAC.
// Ports: start/cfg/busy/done/cfg_err control; w_*, a_* load streams;
// psum_in_* / psum_out_* partial-sum streams; mac_* to/from the MAC.
// Optional: PE_WEIGHT_REUSE_EN adds cfg_reuse_w to skip weight reload.
module pe_mac_sequencer
  import pe_pkg::*;
#(
  parameter int IN_BITWIDTH  = 16,
  parameter int OUT_BITWIDTH = 32,
  parameter int FILT_MAX     = FILT_MAX_DEF,
  parameter int ACT_MAX      = ACT_MAX_DEF,
  localparam int TW = $clog2(FILT_MAX + 1),
  localparam int AW = $clog2(ACT_MAX + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [TW-1:0]           cfg_taps,
  input  logic [AW-1:0]           cfg_acts,
  output logic                    busy,
  output logic                    done,
  output logic                    cfg_err,
  input  logic [IN_BITWIDTH-1:0]  w_data,
  input  logic                    w_valid,
  output logic                    w_ready,
  input  logic [IN_BITWIDTH-1:0]  a_data,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [IN_BITWIDTH-1:0]  psum_in,
  input  logic                    psum_in_valid,
  output logic                    psum_in_ready,
  output logic [IN_BITWIDTH-1:0]  mac_a,
  output logic [IN_BITWIDTH-1:0]  mac_w,
  output logic [IN_BITWIDTH-1:0]  mac_sum,
  output logic                    mac_en,
  input  logic [OUT_BITWIDTH-1:0] mac_out,
  output logic [OUT_BITWIDTH-1:0] psum_out,
  output logic                    psum_out_valid,
  input  logic                    psum_out_ready
`ifdef PE_WEIGHT_REUSE_EN
  ,
  input  logic                    cfg_reuse_w
`endif
);

  localparam int WAW = (FILT_MAX > 1) ? $clog2(FILT_MAX) : 1;
  localparam int AAW = (ACT_MAX > 1) ? $clog2(ACT_MAX) : 1;

  seq_state_t state_q, state_d;
  logic [TW-1:0] taps_q, taps_d;
  logic [AW-1:0] acts_q, acts_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW-1:0] o_q, o_d;
  logic [TW-1:0] k_q, k_d;
  logic          err_q, err_d;

  logic                   we_w, we_a, issue, cfg_bad, reuse_hit;
  logic [AW-1:0]          a_addr;
  logic [IN_BITWIDTH-1:0] w_rd, a_rd;

`ifdef PE_WEIGHT_REUSE_EN
  logic          res_q, res_d;
  logic [TW-1:0] res_taps_q, res_taps_d;
  assign reuse_hit = cfg_reuse_w && res_q && (res_taps_q == cfg_taps);
`else
  assign reuse_hit = 1'b0;
`endif

  assign cfg_bad = (cfg_taps == '0)
                || (cfg_taps > TW'(FILT_MAX))
                || (cfg_acts > AW'(ACT_MAX))
                || (AW'(cfg_taps) > cfg_acts);

  assign a_addr  = o_q + AW'(k_q);
  assign cfg_err = err_q;

  pe_spad #(.WIDTH(IN_BITWIDTH), .DEPTH(FILT_MAX)) u_wspad (
    .clk     (clk),
    .we_i    (we_w),
    .waddr_i (idx_q[WAW-1:0]),
    .wdata_i (w_data),
    .raddr_i (k_q[WAW-1:0]),
    .rdata_o (w_rd)
  );

  pe_spad #(.WIDTH(IN_BITWIDTH), .DEPTH(ACT_MAX)) u_aspad (
    .clk     (clk),
    .we_i    (we_a),
    .waddr_i (idx_q[AAW-1:0]),
    .wdata_i (a_data),
    .raddr_i (a_addr[AAW-1:0]),
    .rdata_o (a_rd)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      taps_q  <= '0;
      acts_q  <= '0;
      idx_q   <= '0;
      o_q     <= '0;
      k_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      taps_q  <= taps_d;
      acts_q  <= acts_d;
      idx_q   <= idx_d;
      o_q     <= o_d;
      k_q     <= k_d;
      err_q   <= err_d;
    end
  end

`ifdef PE_WEIGHT_REUSE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_q      <= 1'b0;
      res_taps_q <= '0;
    end else begin
      res_q      <= res_d;
      res_taps_q <= res_taps_d;
    end
  end
`endif

  always_comb begin
    state_d        = state_q;
    taps_d         = taps_q;
    acts_d         = acts_q;
    idx_d          = idx_q;
    o_d            = o_q;
    k_d            = k_q;
    err_d          = err_q;
`ifdef PE_WEIGHT_REUSE_EN
    res_d          = res_q;
    res_taps_d     = res_taps_q;
`endif
    we_w           = 1'b0;
    we_a           = 1'b0;
    issue          = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    w_ready        = 1'b0;
    a_ready        = 1'b0;
    psum_in_ready  = 1'b0;
    mac_a          = '0;
    mac_w          = '0;
    mac_sum        = '0;
    mac_en         = 1'b0;
    psum_out       = '0;
    psum_out_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          taps_d = cfg_taps;
          acts_d = cfg_acts;
          idx_d  = '0;
          o_d    = '0;
          k_d    = '0;
          err_d  = cfg_bad;
          if (cfg_bad) begin
            state_d = S_DONE;
`ifdef PE_WEIGHT_REUSE_EN
            res_d   = 1'b0;
`endif
          end else if (reuse_hit) begin
            state_d = S_LOAD_A;
          end else begin
            state_d = S_LOAD_W;
`ifdef PE_WEIGHT_REUSE_EN
            // Row is being overwritten; not resident until complete.
            res_d   = 1'b0;
`endif
          end
        end
      end
      S_LOAD_W: begin
        busy    = 1'b1;
        w_ready = 1'b1;
        if (w_valid) begin
          we_w = 1'b1;
          if (idx_q == AW'(taps_q) - AW'(1)) begin
            idx_d   = '0;
            state_d = S_LOAD_A;
`ifdef PE_WEIGHT_REUSE_EN
            res_d      = 1'b1;
            res_taps_d = taps_q;
`endif
          end else begin
            idx_d = idx_q + AW'(1);
          end
        end
      end
      S_LOAD_A: begin
        busy    = 1'b1;
        a_ready = 1'b1;
        if (a_valid) begin
          we_a = 1'b1;
          if (idx_q == acts_q - AW'(1)) begin
            idx_d   = '0;
            o_d     = '0;
            k_d     = '0;
            state_d = S_COMPUTE;
          end else begin
            idx_d = idx_q + AW'(1);
          end
        end
      end
      S_COMPUTE: begin
        busy  = 1'b1;
        mac_a = a_rd;
        mac_w = w_rd;
        if (k_q == '0) begin
          psum_in_ready = 1'b1;
          mac_sum       = psum_in;
          issue         = psum_in_valid;
        end else begin
          // MAC sum_in is narrow; running sum wraps here.
          mac_sum = mac_out[IN_BITWIDTH-1:0];
          issue   = 1'b1;
        end
        mac_en = issue;
        if (issue) begin
          if (k_q == taps_q - TW'(1)) begin
            k_d     = '0;
            state_d = S_OUT;
          end else begin
            k_d = k_q + TW'(1);
          end
        end
      end
      S_OUT: begin
        busy           = 1'b1;
        psum_out       = mac_out;
        psum_out_valid = 1'b1;
        if (psum_out_ready) begin
          if (o_q == acts_q - AW'(taps_q)) begin
            state_d = S_DONE;
          end else begin
            o_d     = o_q + AW'(1);
            k_d     = '0;
            state_d = S_COMPUTE;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
